// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared definitions for the regfile instruction sequencer.
//   - opcode encodings of the 3-bit opcode field
//   - sequencer state enumeration
//   - instruction field positions and small field-extraction helpers
// Configuration macro: REGFILE_SEQ_ADDI_EN (opcode 101 legal as ADDI when defined).
package regfile_seq_pkg;

  // Opcodes, instruction bits [15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS0_LSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned IMM_LSB = 0;

  // Architectural register numbers with special meaning
  localparam logic [2:0] PC_REG   = 3'd7;
  localparam logic [2:0] ZERO_SEL = 3'd0;

  typedef enum logic [2:0] {
    S_WAIT,
    S_FETCH_PC,
    S_FETCH_REQ,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_e;

  function automatic logic [2:0] field3(input logic [15:0] ins, input int unsigned lsb);
    return ins[lsb +: 3];
  endfunction

  function automatic logic [3:0] field_imm4(input logic [15:0] ins);
    return ins[IMM_LSB +: 4];
  endfunction

  // Opcodes the sequencer executes; everything else halts as illegal.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_HALT: legal = 1'b1;
`ifdef REGFILE_SEQ_ADDI_EN
      OP_ADDI: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu: combinational ALU of the regfile sequencer.
//   op     in  3   opcode
//   a      in  16  source operand 0 (rs0)
//   b      in  16  source operand 1 (rs1)
//   imm4   in  4   immediate (present only with REGFILE_SEQ_ADDI_EN)
//   result out 16  result, modulo 2^16, no flags
// Configuration macro: REGFILE_SEQ_ADDI_EN adds the ADDI path and the imm4 port.
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
`ifdef REGFILE_SEQ_ADDI_EN
  input  logic [3:0]  imm4,
`endif
  output logic [15:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
`ifdef REGFILE_SEQ_ADDI_EN
      OP_ADDI: result = a + {12'd0, imm4};
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: instruction sequencer driving a regfile from its control side.
// Fetches 16-bit instructions at the address in R7 (PC), decodes them, reads
// the two source registers, executes on regfile_seq_alu and writes back.
//   clk        in   system clock, all state updates on posedge
//   reset      in   synchronous active-high reset
//   mem_req    out  fetch request, held until mem_ack
//   mem_addr   out  fetch address (PC), holds last value when idle
//   mem_ack    in   fetch complete, mem_rdata valid this cycle
//   mem_rdata  in   fetched instruction
//   regr0s/regr1s out  regfile read selects
//   regr0/regr1   in   regfile read data (valid one cycle after select)
//   regws/regw/we out  regfile write select / data / enable
//   incr_pc    out  R7 += 2 strobe, one pulse per fetched instruction
//   halted     out  HALT or illegal opcode executed, sticky until reset
//   illegal    out  illegal opcode seen, sticky until reset
// Parameter RESET_WAIT (0..15): idle cycles after reset release before fetch.
// Configuration macro: REGFILE_SEQ_ADDI_EN (opcode 101 executes ADDI).
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int unsigned RESET_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  regr0s,
  output logic [2:0]  regr1s,
  input  logic [15:0] regr0,
  input  logic [15:0] regr1,
  output logic [2:0]  regws,
  output logic [15:0] regw,
  output logic        we,
  output logic        incr_pc,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT);

  state_e      state_q;
  logic [15:0] ir_q;
  logic [3:0]  wait_cnt_q;
  logic        mem_req_q;
  logic [15:0] mem_addr_q;
  logic [2:0]  regr0s_q;
  logic [2:0]  regr1s_q;
  logic [2:0]  regws_q;
  logic [15:0] regw_q;
  logic        we_q;
  logic        incr_pc_q;
  logic        halted_q;
  logic        illegal_q;

  logic [2:0]  ir_op;
  logic [2:0]  ir_rd;
  logic        ir_bad;
  logic        ir_stop;
  logic [15:0] alu_result;

  assign ir_op   = field3(ir_q, OP_LSB);
  assign ir_rd   = field3(ir_q, RD_LSB);
  assign ir_bad  = !op_is_legal(ir_op);
  assign ir_stop = (ir_op == OP_HALT) || ir_bad;

  // Source selects are launched straight from mem_rdata on the ack edge so
  // they are valid during DECODE; their copies in IR have no consumer.
`ifdef REGFILE_SEQ_ADDI_EN
  logic [5:0] unused_ir;
  assign unused_ir = {field3(ir_q, RS0_LSB), field3(ir_q, RS1_LSB)};
`else
  logic [9:0] unused_ir;
  assign unused_ir = {field3(ir_q, RS0_LSB), field3(ir_q, RS1_LSB), field_imm4(ir_q)};
`endif

  regfile_seq_alu u_alu (
    .op     (ir_op),
    .a      (regr0),
    .b      (regr1),
`ifdef REGFILE_SEQ_ADDI_EN
    .imm4   (field_imm4(ir_q)),
`endif
    .result (alu_result)
  );

  // Outputs are registered: each transition loads the values the next state
  // presents, so the regfile sees stable controls at the following negedge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      regr0s_q   <= '0;
      regr1s_q   <= '0;
      regws_q    <= '0;
      regw_q     <= '0;
      we_q       <= 1'b0;
      incr_pc_q  <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      // Single-cycle strobes
      we_q      <= 1'b0;
      incr_pc_q <= 1'b0;

      case (state_q)
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q  <= S_FETCH_PC;
            regr0s_q <= PC_REG;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end

        S_FETCH_PC: begin
          state_q    <= S_FETCH_REQ;
          mem_req_q  <= 1'b1;
          mem_addr_q <= regr0;
        end

        S_FETCH_REQ: begin
          if (mem_ack) begin
            state_q   <= S_DECODE;
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            incr_pc_q <= 1'b1;
            regr0s_q  <= field3(mem_rdata, RS0_LSB);
            regr1s_q  <= field3(mem_rdata, RS1_LSB);
          end
        end

        S_DECODE: begin
          if (ir_stop) begin
            state_q   <= S_HALTED;
            halted_q  <= 1'b1;
            illegal_q <= ir_bad;
          end else begin
            state_q <= S_READ;
          end
        end

        S_READ: state_q <= S_EXEC;

        S_EXEC: begin
          state_q <= S_WB;
          regws_q <= ir_rd;
          regw_q  <= alu_result;
          we_q    <= (ir_rd != ZERO_SEL);
        end

        S_WB: begin
          state_q  <= S_FETCH_PC;
          regr0s_q <= PC_REG;
        end

        S_HALTED: state_q <= S_HALTED;

        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign regr0s   = regr0s_q;
  assign regr1s   = regr1s_q;
  assign regws    = regws_q;
  assign regw     = regw_q;
  assign we       = we_q;
  assign incr_pc  = incr_pc_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: self-checking bench for regfile_seq. Provides an
// instruction memory with programmable ack delay, a negedge-sampled regfile,
// and an instruction-level reference model (register array + PC).
module tb_regfile_seq;

  localparam int unsigned RW = 3;
`ifdef REGFILE_SEQ_ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  regr0s, regr1s, regws;
  logic [15:0] regr0 = '0;
  logic [15:0] regr1 = '0;
  logic [15:0] regw;
  logic        we, incr_pc, halted, illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_seq #(.RESET_WAIT(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .regr0s   (regr0s),
    .regr1s   (regr1s),
    .regr0    (regr0),
    .regr1    (regr1),
    .regws    (regws),
    .regw     (regw),
    .we       (we),
    .incr_pc  (incr_pc),
    .halted   (halted),
    .illegal  (illegal)
  );

  // Instruction memory with configurable ack delay; random ack noise while idle
  logic [15:0] imem [0:65535];
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;

  always @(posedge clk) begin
    #2;
    if (reset || !mem_req) begin
      wcnt      = 0;
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end else if (wcnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = imem[mem_addr];
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  // Regfile: samples controls on negedge, read data valid by the next posedge
  logic [15:0] rf [8];
  logic [15:0] poke_val [8];
  logic [7:0]  poke_mask = '0;
  int unsigned poke_seq = 0;
  int unsigned poke_seen = 0;

  always @(negedge clk) begin
    if (poke_seq != poke_seen) begin
      for (int i = 0; i < 8; i++) if (poke_mask[i]) rf[i] = poke_val[i];
      poke_seen = poke_seq;
    end
    if (we) rf[regws] = regw;
    if (incr_pc) rf[7] = rf[7] + 16'd2;
    regr0 = rf[regr0s];
    regr1 = rf[regr1s];
  end

  // Reference model: architectural registers, mrf[7] is the PC
  logic [15:0] mrf [8];

  task automatic poke(input int unsigned idx, input logic [15:0] v);
    poke_val[idx]  = v;
    poke_mask[idx] = 1'b1;
    mrf[idx]       = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_mem_req",  mem_req,  16'd0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_regr0s",   regr0s,   16'd0);
    chk("rst_regr1s",   regr1s,   16'd0);
    chk("rst_regws",    regws,    16'd0);
    chk("rst_regw",     regw,     16'd0);
    chk("rst_we",       we,       16'd0);
    chk("rst_incr_pc",  incr_pc,  16'd0);
    chk("rst_halted",   halted,   16'd0);
    chk("rst_illegal",  illegal,  16'd0);
  endtask

  // Runs one instruction from the current model PC and checks every cycle.
  task automatic do_instr(input int unsigned delay, output logic [15:0] wb_val);
    logic [15:0] ins, a, b, res;
    logic [2:0]  op, rd, s0, s1;
    logic [3:0]  imm;
    logic        ill, hlt;
    int unsigned n;
    ack_delay = delay;
    wb_val = '0;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("fetch_req", mem_req, 16'd1);
    chk("fetch_addr", mem_addr, mrf[7]);
    ins = imem[mrf[7]];
    op  = ins[15:13];
    rd  = ins[12:10];
    s0  = ins[9:7];
    s1  = ins[6:4];
    imm = ins[3:0];
    for (int i = 0; i < int'(delay); i++) begin
      tick();
      chk("req_hold", mem_req, 16'd1);
      chk("addr_hold", mem_addr, mrf[7]);
    end
    tick();
    chk("dec_incr_pc", incr_pc, 16'd1);
    chk("dec_we", we, 16'd0);
    chk("dec_req", mem_req, 16'd0);
    mrf[7] = mrf[7] + 16'd2;
    a   = mrf[s0];
    b   = mrf[s1];
    ill = (op == 3'd6) || (op == 3'd5 && !ADDI_ON);
    hlt = (op == 3'd7);
    if (ill || hlt) begin
      tick();
      chk("halted", halted, 16'd1);
      chk("illegal", illegal, {15'd0, ill});
      chk("halt_incr_pc", incr_pc, 16'd0);
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("halt_quiet", {13'd0, mem_req, we, incr_pc}, 16'd0);
      end
    end else begin
      case (op)
        3'd0:    res = a + b;
        3'd1:    res = a - b;
        3'd2:    res = a & b;
        3'd3:    res = a | b;
        3'd4:    res = a ^ b;
        default: res = a + 16'(imm);
      endcase
      tick();
      chk("read_strobes", {14'd0, we, incr_pc}, 16'd0);
      tick();
      chk("exec_we", we, 16'd0);
      tick();
      chk("wb_we", we, {15'd0, rd != 3'd0});
      chk("wb_incr_pc", incr_pc, 16'd0);
      chk("wb_halted", halted, 16'd0);
      if (rd != 3'd0) begin
        chk("wb_regws", regws, {13'd0, rd});
        chk("wb_regw", regw, res);
        mrf[rd] = res;
      end
      wb_val = regw;
      tick();
      chk("fetch_pc_idle", {14'd0, mem_req, we}, 16'd0);
      tick();
      chk("next_req_latency", mem_req, 16'd1);
    end
  endtask

  initial begin
    logic [15:0] wv;
    logic [2:0]  rop, rrd, rs0, rs1;
    logic [3:0]  rimm;
    int unsigned n;

    // Program image
    for (int i = 0; i < 65536; i++) imem[i] = 16'hE000;
    imem[16'h0000] = 16'h0CA0;           // ADD  r3 = r1 + r2
    imem[16'h0002] = 16'h34A0;           // SUB  r5 = r1 - r2
    imem[16'h0004] = 16'h80A0;           // XOR  r0 = r1 ^ r2 (discarded)
    for (int k = 0; k < 30; k++) begin
      rop  = 3'($urandom_range(0, ADDI_ON ? 5 : 4));
      rrd  = 3'($urandom_range(0, 6));
      rs0  = 3'($urandom_range(0, 6));
      rs1  = 3'($urandom_range(0, 6));
      rimm = 4'($urandom);
      imem[16'(6 + 2 * k)] = {rop, rrd, rs0, rs1, rimm};
    end
    imem[16'h0042] = 16'h1F00;           // ADD  r7 = r6 + r0 (jump)
    imem[16'h0100] = 16'hB08F;           // ADDI r4 = r1 + 0xF
    imem[16'h0102] = 16'hE000;           // HALT
    imem[16'h0104] = 16'hC000;           // illegal opcode

    poke_mask = '0;
    for (int i = 0; i < 7; i++) poke(i, 16'($urandom));
    poke(1, 16'd5);
    poke(2, 16'd7);
    poke(7, 16'h0000);
    poke_seq++;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk_reset();
    reset = 1'b0;

    // ADD with immediate ack
    do_instr(0, wv);
    chk("add_result", wv, 16'd12);
    chk("pc_plus2", mem_addr, 16'd2);

    // SUB wraps
    poke_mask = '0;
    poke(1, 16'h0000);
    poke(2, 16'h0001);
    poke_seq++;
    do_instr(0, wv);
    chk("sub_wrap", wv, 16'hFFFF);

    // XOR to r0 with a 3-cycle ack delay
    do_instr(3, wv);

    // Random instruction stream with random ack delays
    for (int k = 0; k < 30; k++) do_instr($urandom_range(0, 3), wv);

    // Jump through R7
    poke_mask = '0;
    poke(6, 16'h0100);
    poke(0, 16'h0000);
    poke_seq++;
    do_instr(1, wv);
    chk("jump_target", mem_addr, 16'h0100);

    // ADDI with carry out of imm4
    poke_mask = '0;
    poke(1, 16'hFFFF);
    poke_seq++;
    do_instr(0, wv);
`ifdef REGFILE_SEQ_ADDI_EN
    chk("addi_result", wv, 16'h000E);
    do_instr(0, wv);                      // HALT
    chk("halt_not_illegal", illegal, 16'd0);
`else
    chk("addi_illegal", illegal, 16'd1);
`endif

    // Reset in the middle of a pending fetch
    ack_delay = 6;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("refetch_req", mem_req, 16'd1);
    chk("refetch_addr", mem_addr, mrf[7]);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset();
    reset = 1'b0;
    for (int i = 0; i < int'(RW) + 1; i++) begin
      tick();
      chk("wait_idle", mem_req, 16'd0);
    end
    tick();
    chk("restart_req", mem_req, 16'd1);
    chk("restart_addr", mem_addr, mrf[7]);
    do_instr(0, wv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
